// File: rtl/pktmux_pkg.sv
// pktmux_pkg: shared FSM encoding, default sizes and grant decode helper.
package pktmux_pkg;

    localparam int NIN_DEF = 4;
    localparam int DW_DEF  = 64;

    // IDLE: between packets; PKT: a packet has started but its LAST is not yet accepted.
    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    // One-hot to index. A multi-hot input resolves to the lowest set bit; zero yields 0.
    function automatic int onehot_idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/pkt_outreg.sv
// pkt_outreg: registered output beat (DATA + LAST) with VALID/READY handshake.
// The clear input drops any held beat regardless of READY.
module pkt_outreg #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clear,
    input  logic [DW-1:0] d_data,
    input  logic          d_last,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic          last
);

    // Capture on load, drain on downstream accept, hold otherwise; clear wins over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            last  <= d_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pktmux.sv
// pktmux: forwards the granted source's AXI-stream packet onto one registered
// output port and holds the arbiter grant (o_stall) until LAST is accepted.
// Optional feature macro PKTMUX_ABORT_EN adds per-source ABORT inputs and an
// M_AXIN_ABORT pulse output that terminate a packet early.
module pktmux
    import pktmux_pkg::*;
#(
    parameter int NIN = NIN_DEF,
    parameter int DW  = DW_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NIN-1:0]    i_grant,
    output logic              o_stall,
    output logic [NIN-1:0]    o_req,
    input  logic [NIN-1:0]    S_AXIN_VALID,
    output logic [NIN-1:0]    S_AXIN_READY,
    input  logic [NIN*DW-1:0] S_AXIN_DATA,
    input  logic [NIN-1:0]    S_AXIN_LAST,
`ifdef PKTMUX_ABORT_EN
    input  logic [NIN-1:0]    S_AXIN_ABORT,
    output logic              M_AXIN_ABORT,
`endif
    output logic              M_AXIN_VALID,
    input  logic              M_AXIN_READY,
    output logic [DW-1:0]     M_AXIN_DATA,
    output logic              M_AXIN_LAST
);

    localparam int SW = (NIN > 1) ? $clog2(NIN) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] sel;
    logic          grant_any;
    logic          out_free;
    logic          ready_sel;
    logic          accept;
    logic          acc_last;
    logic          abort_hit;
    logic          sel_valid;
    logic          sel_last;
    logic [DW-1:0] sel_data;

    assign sel       = SW'(onehot_idx(32'(i_grant)));
    assign grant_any = |i_grant;
    assign sel_valid = S_AXIN_VALID[sel];
    assign sel_last  = S_AXIN_LAST[sel];
    assign sel_data  = S_AXIN_DATA[sel*DW +: DW];
    assign o_req     = S_AXIN_VALID;

    // Output slot is free when empty or being drained this cycle.
    assign out_free  = !M_AXIN_VALID || M_AXIN_READY;

`ifdef PKTMUX_ABORT_EN
    // Abort only counts inside a packet; an abort in IDLE is ignored.
    assign abort_hit = grant_any && (state == PKT) && S_AXIN_ABORT[sel];
`else
    assign abort_hit = 1'b0;
`endif

    // Reset gates the combinational handshake so nothing is accepted while held in reset.
    assign ready_sel = i_reset_n && grant_any && out_free && !abort_hit;
    assign accept    = ready_sel && sel_valid;
    assign acc_last  = accept && sel_last;

    // Release the grant in the cycle LAST is accepted (or the packet aborts).
    assign o_stall   = i_reset_n && grant_any && !acc_last && !abort_hit;

    // Only the selected source sees READY.
    always_comb begin
        S_AXIN_READY      = '0;
        S_AXIN_READY[sel] = ready_sel;
    end

    // Packet-tracking state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Enter PKT on a non-LAST first beat; leave on accepted LAST or abort.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !sel_last)  state_nxt = PKT;
            PKT:     if (acc_last || abort_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef PKTMUX_ABORT_EN
    // One-cycle registered abort pulse, independent of downstream READY.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) M_AXIN_ABORT <= 1'b0;
        else            M_AXIN_ABORT <= abort_hit;
    end
`endif

    pkt_outreg #(.DW(DW)) u_outreg (
        .clk    (i_clk),
        .rst_n  (i_reset_n),
        .load   (accept),
        .clear  (abort_hit),
        .d_data (sel_data),
        .d_last (sel_last),
        .ready  (M_AXIN_READY),
        .valid  (M_AXIN_VALID),
        .data   (M_AXIN_DATA),
        .last   (M_AXIN_LAST)
    );

endmodule
